product_accumulator: RTL and testbench
======================================

Name: product_accumulator

Overview:
- Downstream consumer of the 8x8 registered serial multiplier.
- Takes a stream of unsigned 16-bit products and sums a group of `len` consecutive products into a wider accumulator, i.e. the add half of a dot-product / MAC datapath.
- Presents each group result on a valid/ready output, with saturation and a sticky overflow flag.
- The upstream wrapper drives in_valid aligned with the multiplier's registered output.

Parameters:
- IN_W, 16: width of incoming product.
- ACC_W, 24: accumulator/result width; must be >= IN_W.
- CNT_W, 8: width of group length and internal beat counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- in_valid  input  1  product beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_data  input  IN_W  unsigned product.
- len  input  CNT_W  products per group; sampled only on the first beat of a group.
- out_valid  output  1  group result valid.
- out_ready  input  1  consumer accepts result.
- out_data  output  ACC_W  accumulated sum, saturated.
- out_ovf  output  1  saturation occurred during this group.
- busy  output  1  a group is in progress or its result is pending.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE; accumulator, counter and target all 0.
  - out_valid=0, out_data=0, out_ovf=0, busy=0.
  - in_ready=1 once reset is released.
  - Reset mid-group discards all partial state; no result is emitted.
- Beat acceptance: a beat is accepted iff in_valid && in_ready at the rising clk edge. in_data is ignored otherwise.
- States:
  - IDLE: in_ready=1, busy=0.
    - On an accepted beat: acc <= zero-extended in_data; cnt <= 1; target <= (len==0 ? 1 : len); ovf <= 0.
    - Next state is DONE if target==1, else ACC.
  - ACC: in_ready=1, busy=1.
    - On an accepted beat: acc <= sat(acc + in_data); cnt <= cnt+1.
    - Next state is DONE when cnt+1 == target, else stay in ACC.
    - Cycles with in_valid=0 (gaps) hold all state.
  - DONE: in_ready=0, busy=1, out_valid=1.
    - On out_valid && out_ready: next state is IDLE, out_valid falls next cycle.
    - No beat is accepted in the handshake cycle (no bypass).
- Latency: out_valid rises in the cycle after the final beat is accepted.
  - Minimum group period is target+1 cycles.
- Arithmetic:
  - All data is unsigned; the sum is computed ACC_W+1 bits wide.
  - If the sum >= 2^ACC_W: acc <= all ones and ovf <= 1.
  - ovf is sticky for the whole group and cleared on the first beat of the next group.
- Output stability:
  - out_data and out_ovf are the acc/ovf registers.
  - Both are stable while out_valid && !out_ready.
  - Both hold the last result in IDLE until the next group's first beat.
- len changes after the first beat of a group have no effect on that group.
- len==0 is treated as 1.
- Maximum group length is 2^CNT_W - 1.

Test Plan:
1. len=4, beats 100,200,300,400 on consecutive cycles -> out_valid 1 cycle after 4th accept, out_data=1000, out_ovf=0, busy high from 1st accept until handshake.
2. len=0 with in_data=0xFFFF, then len=1 with in_data=0x0001 -> two single-beat groups, out_data=65535 then 1, out_ovf=0 both.
3. len=3, beats 5,7,9 with two idle cycles between each; out_ready low for 5 cycles after out_valid -> out_data=21 held stable, in_ready=0, extra in_valid beats not accepted; result consumed on out_ready=1.
4. ACC_W=17, len=3, beats 0xFFFF x3 -> out_data=0x1FFFF, out_ovf=1; next group len=2 of 1,2 -> out_data=3, out_ovf=0.
5. len=4, rst pulsed low after 2 beats -> outputs 0 immediately, state IDLE; new group len=2 of 10,20 -> out_data=30.
6. len changed from 3 to 1 after first beat of a 3-beat group of 1,1,1 -> result emitted after 3 beats, out_data=3.

Source files
------------

// File: rtl/product_accumulator.sv
// Group accumulator for the multiplier product stream: sums `len` consecutive
// unsigned products with saturation and presents each total on a valid/ready port.
module product_accumulator #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned ACC_W = 24,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [CNT_W-1:0] len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf,
  output logic             busy
);

  localparam int unsigned SUM_W = ACC_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] target;
  logic             ovf;

  logic             accept_c;
  logic [SUM_W-1:0] sum_c;
  logic [CNT_W-1:0] cnt_inc_c;

  // One extra bit on the sum exposes the carry used for saturation.
  always_comb begin
    accept_c  = in_valid && in_ready;
    sum_c     = {1'b0, acc} + SUM_W'(in_data);
    cnt_inc_c = cnt + CNT_W'(1);
  end

  // State, datapath and handshake flags all update together so the outputs
  // come straight from flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      target    <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_c) begin
            acc    <= ACC_W'(in_data);
            cnt    <= CNT_W'(1);
            target <= (len == '0) ? CNT_W'(1) : len;
            ovf    <= 1'b0;
            busy   <= 1'b1;
            // len of 0 or 1 is a single-beat group
            if (len <= CNT_W'(1)) begin
              state     <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              state <= ACC;
            end
          end
        end
        ACC: begin
          if (accept_c) begin
            if (sum_c[ACC_W]) begin
              acc <= '1;
              ovf <= 1'b1;
            end else begin
              acc <= sum_c[ACC_W-1:0];
            end
            cnt <= cnt_inc_c;
            if (cnt_inc_c == target) begin
              state     <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_data = acc;
  assign out_ovf  = ovf;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: default 24-bit instance plus a 17-bit
// instance sharing the same stimulus to exercise saturation.
module tb_product_accumulator;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic [7:0]  len;
  logic        out_ready;

  logic        in_ready;
  logic        out_valid;
  logic [23:0] out_data;
  logic        out_ovf;
  logic        busy;

  logic        in_ready17;
  logic        out_valid17;
  logic [16:0] out_data17;
  logic        out_ovf17;
  logic        busy17;

  int checks;
  int errors;

  product_accumulator dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .len       (len),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  product_accumulator #(.IN_W(16), .ACC_W(17), .CNT_W(8)) dut17 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready17),
    .in_data   (in_data),
    .len       (len),
    .out_valid (out_valid17),
    .out_ready (out_ready),
    .out_data  (out_data17),
    .out_ovf   (out_ovf17),
    .busy      (busy17)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one beat for one rising edge; returns at the following falling edge.
  task automatic beat(input logic [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    len       = '0;
    out_ready = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data",  32'(out_data),  32'h0);
    chk("rst_out_ovf",   32'(out_ovf),   32'h0);
    chk("rst_busy",      32'(busy),      32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'h1);

    // 1: four consecutive beats
    len = 8'd4;
    beat(16'd100);
    chk("t1_busy_first", 32'(busy), 32'h1);
    beat(16'd200);
    beat(16'd300);
    chk("t1_no_valid_early", 32'(out_valid), 32'h0);
    beat(16'd400);
    chk("t1_out_valid", 32'(out_valid), 32'h1);
    chk("t1_out_data",  32'(out_data),  32'd1000);
    chk("t1_out_ovf",   32'(out_ovf),   32'h0);
    chk("t1_in_ready",  32'(in_ready),  32'h0);
    handshake();
    chk("t1_valid_fall", 32'(out_valid), 32'h0);
    chk("t1_busy_fall",  32'(busy),      32'h0);
    chk("t1_data_hold",  32'(out_data),  32'd1000);
    chk("t1_in_ready_back", 32'(in_ready), 32'h1);

    // 2: len=0 and len=1 single-beat groups
    len = 8'd0;
    beat(16'hFFFF);
    chk("t2a_out_valid", 32'(out_valid), 32'h1);
    chk("t2a_out_data",  32'(out_data),  32'd65535);
    chk("t2a_out_ovf",   32'(out_ovf),   32'h0);
    chk("t2a_data17",    32'(out_data17), 32'd65535);
    handshake();
    len = 8'd1;
    beat(16'h0001);
    chk("t2b_out_valid", 32'(out_valid), 32'h1);
    chk("t2b_out_data",  32'(out_data),  32'd1);
    chk("t2b_out_ovf",   32'(out_ovf),   32'h0);
    handshake();

    // 3: gaps between beats, back-pressure on the result
    len = 8'd3;
    beat(16'd5);
    @(negedge clk);
    @(negedge clk);
    chk("t3_gap_busy", 32'(busy), 32'h1);
    chk("t3_gap_hold", 32'(out_data), 32'd5);
    beat(16'd7);
    @(negedge clk);
    @(negedge clk);
    chk("t3_gap_valid", 32'(out_valid), 32'h0);
    beat(16'd9);
    chk("t3_out_valid", 32'(out_valid), 32'h1);
    chk("t3_out_data",  32'(out_data),  32'd21);
    in_valid = 1'b1;
    in_data  = 16'h1234;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_stall_valid",    32'(out_valid), 32'h1);
      chk("t3_stall_data",     32'(out_data),  32'd21);
      chk("t3_stall_in_ready", 32'(in_ready),  32'h0);
    end
    in_valid = 1'b0;
    handshake();
    chk("t3_consumed_valid", 32'(out_valid), 32'h0);
    chk("t3_consumed_data",  32'(out_data),  32'd21);

    // 4: saturation on the 17-bit instance, then ovf clears on the next group
    len = 8'd3;
    beat(16'hFFFF);
    beat(16'hFFFF);
    chk("t4_pre_sat17", 32'(out_data17), 32'h1FFFE);
    chk("t4_pre_ovf17", 32'(out_ovf17),  32'h0);
    beat(16'hFFFF);
    chk("t4_valid17", 32'(out_valid17), 32'h1);
    chk("t4_data17",  32'(out_data17),  32'h1FFFF);
    chk("t4_ovf17",   32'(out_ovf17),   32'h1);
    chk("t4_data24",  32'(out_data),    32'h2FFFD);
    chk("t4_ovf24",   32'(out_ovf),     32'h0);
    handshake();
    chk("t4_ovf17_hold", 32'(out_ovf17), 32'h1);
    len = 8'd2;
    beat(16'd1);
    chk("t4_ovf17_clear", 32'(out_ovf17), 32'h0);
    beat(16'd2);
    chk("t4b_valid17", 32'(out_valid17), 32'h1);
    chk("t4b_data17",  32'(out_data17),  32'd3);
    chk("t4b_ovf17",   32'(out_ovf17),   32'h0);
    chk("t4b_data24",  32'(out_data),    32'd3);
    handshake();

    // 5: asynchronous reset in the middle of a group
    len = 8'd4;
    beat(16'd1);
    beat(16'd2);
    rst = 1'b0;
    #1;
    chk("t5_rst_data",  32'(out_data),  32'h0);
    chk("t5_rst_busy",  32'(busy),      32'h0);
    chk("t5_rst_valid", 32'(out_valid), 32'h0);
    chk("t5_rst_ovf",   32'(out_ovf),   32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_in_ready", 32'(in_ready), 32'h1);
    len = 8'd2;
    beat(16'd10);
    chk("t5_not_done", 32'(out_valid), 32'h0);
    beat(16'd20);
    chk("t5_out_valid", 32'(out_valid), 32'h1);
    chk("t5_out_data",  32'(out_data),  32'd30);
    handshake();

    // 6: len changes after the first beat are ignored
    len = 8'd3;
    beat(16'd1);
    len = 8'd1;
    beat(16'd1);
    chk("t6_mid_valid", 32'(out_valid), 32'h0);
    beat(16'd1);
    chk("t6_out_valid", 32'(out_valid), 32'h1);
    chk("t6_out_data",  32'(out_data),  32'd3);
    handshake();
    chk("t6_idle_busy", 32'(busy), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
